// File: rtl/notch_coeff_sequencer_pkg.sv
// notch_coeff_sequencer_pkg: shared control bits, coefficient word indices and FSM states
package notch_coeff_sequencer_pkg;
  localparam int CTRL_COMMIT = 0;
  localparam int CTRL_CLEAR  = 1;
  localparam logic [2:0] LP1A_KX_R = 3'd0;
  localparam logic [2:0] LP1A_KX_I = 3'd1;
  localparam logic [2:0] LP1A_KY_R = 3'd2;
  localparam logic [2:0] LP1A_KY_I = 3'd3;
  localparam logic [2:0] LP1B_KX_R = 3'd4;
  localparam logic [2:0] LP1B_KX_I = 3'd5;
  localparam logic [2:0] LP1B_KY_R = 3'd6;
  localparam logic [2:0] LP1B_KY_I = 3'd7;
  typedef enum logic [1:0] {IDLE, WAIT_SYNC, WRITE, DONE} state_t;
endpackage

// File: rtl/notch_coeff_sequencer_if.sv
// notch_coeff_sequencer_if: local-bus, iq phase and coefficient port bundle
interface notch_coeff_sequencer_if #(parameter int DW = 18);
  logic [15:0]          lb_addr;
  logic [31:0]          lb_data;
  logic                 lb_write;
  logic                 iq;
  logic                 coef_we;
  logic [2:0]           coef_addr;
  logic signed [DW-1:0] coef_data;
  logic                 busy;
  logic                 done;
  logic                 overrun;
  logic                 timeout;
  modport master (output lb_addr, lb_data, lb_write, iq,
                  input  coef_we, coef_addr, coef_data, busy, done, overrun, timeout);
  modport slave  (input  lb_addr, lb_data, lb_write, iq,
                  output coef_we, coef_addr, coef_data, busy, done, overrun, timeout);
endinterface

// File: rtl/notch_coeff_stage.sv
// notch_coeff_stage: 8-word staging register file with local-bus write decode
module notch_coeff_stage #(
  parameter int DW   = 18,
  parameter int BASE = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [15:0]          lb_addr_i,
  input  logic [31:0]          lb_data_i,
  input  logic                 lb_write_i,
  input  logic [2:0]           rd_idx_i,
  output logic signed [DW-1:0] rd_data_o
);
  logic signed [DW-1:0] stage_q [8];
  logic [15:0] off;
  logic        hit;
  logic        unused_hi;
  assign off       = lb_addr_i - 16'(BASE);
  assign hit       = lb_write_i && off < 16'd8;
  assign rd_data_o = stage_q[rd_idx_i];
  assign unused_hi = ^lb_data_i[31:DW];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) stage_q[i] <= '0;
    end else if (hit) begin
      stage_q[off[2:0]] <= lb_data_i[DW-1:0];
    end
  end
endmodule

// File: rtl/notch_coeff_sequencer.sv
// notch_coeff_sequencer: replays staged coefficients as an 8-word burst aligned to the I/Q pair
module notch_coeff_sequencer
  import notch_coeff_sequencer_pkg::*;
#(
  parameter int DW           = 18,
  parameter int BASE         = 0,
  parameter int SYNC_TIMEOUT = 16
) (
  input logic clk,
  input logic rst_n,
  notch_coeff_sequencer_if.slave bus
);
  localparam int CW = $clog2(SYNC_TIMEOUT + 1);
  state_t               state_q;
  logic [CW-1:0]        cnt_q;
  logic                 coef_we_q, busy_q, done_q, overrun_q, timeout_q;
  logic [2:0]           coef_addr_q;
  logic signed [DW-1:0] coef_data_q;
  logic [2:0]           rd_idx_d;
  logic signed [DW-1:0] rd_data;
  logic                 ctrl_wr, commit, clear;
  assign ctrl_wr  = bus.lb_write && bus.lb_addr == 16'(BASE + 8);
  assign commit   = ctrl_wr && bus.lb_data[CTRL_COMMIT];
  assign clear    = ctrl_wr && bus.lb_data[CTRL_CLEAR];
  // staging is read at the edge that emits the word, so late writes still make it in
  assign rd_idx_d = state_q == WRITE ? coef_addr_q + 3'd1 : LP1A_KX_R;
  notch_coeff_stage #(.DW(DW), .BASE(BASE)) u_stage (
    .clk        (clk),
    .rst_n      (rst_n),
    .lb_addr_i  (bus.lb_addr),
    .lb_data_i  (bus.lb_data),
    .lb_write_i (bus.lb_write),
    .rd_idx_i   (rd_idx_d),
    .rd_data_o  (rd_data)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      coef_we_q   <= 1'b0;
      coef_addr_q <= LP1A_KX_R;
      coef_data_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      overrun_q <= (overrun_q && !clear) || (commit && state_q != IDLE);
      timeout_q <= timeout_q && !clear;
      case (state_q)
        IDLE: if (commit) begin
          state_q <= WAIT_SYNC;
          busy_q  <= 1'b1;
          cnt_q   <= '0;
        end
        WAIT_SYNC: if (bus.iq || cnt_q == CW'(SYNC_TIMEOUT - 1)) begin
          state_q     <= WRITE;
          coef_we_q   <= 1'b1;
          coef_addr_q <= LP1A_KX_R;
          coef_data_q <= rd_data;
          if (!bus.iq) timeout_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
        WRITE: if (coef_addr_q == LP1B_KY_I) begin
          state_q   <= DONE;
          coef_we_q <= 1'b0;
          busy_q    <= 1'b0;
          done_q    <= 1'b1;
        end else begin
          coef_addr_q <= rd_idx_d;
          coef_data_q <= rd_data;
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.coef_we   = coef_we_q;
  assign bus.coef_addr = coef_addr_q;
  assign bus.coef_data = coef_data_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.overrun   = overrun_q;
  assign bus.timeout   = timeout_q;
endmodule

// File: tb/tb_notch_coeff_sequencer.sv
// tb_notch_coeff_sequencer: directed vectors for burst, overrun, timeout, reset and late staging writes
module tb_notch_coeff_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic iq_tog = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   wr_addr[$], wr_data[$], wr_iq[$], wr_cyc[$];
  int   done_n = 0, done_cyc = 0, done_busy = 0;
  int   exp_a[8], exp_b[8], exp_c[8], exp_d[8];

  notch_coeff_sequencer_if #(.DW(18)) bus ();
  notch_coeff_sequencer #(.DW(18), .BASE(0), .SYNC_TIMEOUT(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial forever begin
    @(posedge clk);
    #2;
    if (iq_tog) bus.iq = ~bus.iq;
  end

  always @(negedge clk) begin
    if (bus.coef_we) begin
      wr_addr.push_back(int'(bus.coef_addr));
      wr_data.push_back(int'(bus.coef_data));
      wr_iq.push_back(int'(bus.iq));
      wr_cyc.push_back(cyc);
    end
    if (bus.done) begin
      done_n++;
      done_cyc  = cyc;
      done_busy = int'(bus.busy);
    end
  end

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic lb_wr(input logic [15:0] a, input logic [31:0] d);
    bus.lb_addr  = a;
    bus.lb_data  = d;
    bus.lb_write = 1'b1;
    @(posedge clk);
    #1 bus.lb_write = 1'b0;
  endtask

  task automatic load(input int v[8]);
    for (int i = 0; i < 8; i++) lb_wr(16'(i), 32'(v[i]));
  endtask

  task automatic start;
    wr_addr.delete(); wr_data.delete(); wr_iq.delete(); wr_cyc.delete();
    done_n = 0;
    lb_wr(16'd8, 32'd1);
  endtask

  task automatic wait_we(input string tag, input int n);
    int t = 0;
    while (wr_addr.size() < n && t < 40) begin
      @(negedge clk);
      #1 t++;
    end
    chk(tag, wr_addr.size() >= n, 1);
  endtask

  task automatic wait_done(input string tag);
    int t = 0;
    while (done_n == 0 && t < 60) begin
      @(posedge clk);
      #1 t++;
    end
    chk({tag, "_done_seen"}, done_n > 0, 1);
  endtask

  task automatic check_burst(input string tag, input int e[8]);
    int n = wr_addr.size();
    chk({tag, "_nwrites"}, n, 8);
    for (int i = 0; i < n && i < 8; i++) begin
      chk($sformatf("%s_addr%0d", tag, i), wr_addr[i], i);
      chk($sformatf("%s_data%0d", tag, i), wr_data[i], e[i]);
      chk($sformatf("%s_cyc%0d", tag, i), wr_cyc[i], wr_cyc[0] + i);
    end
    if (n > 0) begin
      chk({tag, "_first_iq"}, wr_iq[0], 0);
      chk({tag, "_done_cyc"}, done_cyc, wr_cyc[n-1] + 1);
    end
    chk({tag, "_done_n"}, done_n, 1);
    chk({tag, "_done_busy"}, done_busy, 0);
    chk({tag, "_busy_after"}, bus.busy, 0);
    chk({tag, "_we_after"}, bus.coef_we, 0);
  endtask

  initial begin
    exp_a = '{71000, 0, -70000, 0, 0, 0, 0, 0};
    exp_b = '{10, 11, 12, 13, 14, 15, 16, 17};
    exp_c = '{10, 11, 12, 13, 14, 15, 1234, 17};
    exp_d = '{-131072, 131071, 12, 13, 14, 15, 1234, 17};
    bus.lb_addr = '0; bus.lb_data = '0; bus.lb_write = 1'b0; bus.iq = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_we", bus.coef_we, 0);
    chk("rst_addr", bus.coef_addr, 0);
    chk("rst_data", bus.coef_data, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_ovr", bus.overrun, 0);
    chk("rst_tmo", bus.timeout, 0);
    rst_n = 1'b1;
    iq_tog = 1'b1;
    @(posedge clk);
    #1;
    // basic burst with iq toggling
    load(exp_a);
    start();
    chk("t1_busy", bus.busy, 1);
    wait_done("t1");
    check_burst("t1", exp_a);
    // second commit mid-burst
    start();
    wait_we("t2_k2", 3);
    lb_wr(16'd8, 32'd1);
    wait_done("t2");
    check_burst("t2", exp_a);
    chk("t2_ovr_set", bus.overrun, 1);
    lb_wr(16'd8, 32'd2);
    chk("t2_ovr_clr", bus.overrun, 0);
    // iq stuck low
    iq_tog = 1'b0;
    bus.iq = 1'b0;
    @(posedge clk);
    #1;
    start();
    repeat (15) @(posedge clk);
    #1;
    chk("t3_tmo_early", bus.timeout, 0);
    chk("t3_we_early", bus.coef_we, 0);
    @(posedge clk);
    #1;
    chk("t3_tmo_set", bus.timeout, 1);
    chk("t3_we_start", bus.coef_we, 1);
    wait_done("t3");
    check_burst("t3", exp_a);
    lb_wr(16'd8, 32'd2);
    chk("t3_tmo_clr", bus.timeout, 0);
    iq_tog = 1'b1;
    // reset at k=4
    start();
    wait_we("t4_k4", 5);
    chk("t4_addr_k4", bus.coef_addr, 4);
    rst_n = 1'b0;
    #1;
    chk("t4_we_rst", bus.coef_we, 0);
    chk("t4_busy_rst", bus.busy, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("t4_no_more", wr_addr.size(), 5);
    load(exp_a);
    start();
    wait_done("t4b");
    check_burst("t4b", exp_a);
    // late staging writes during burst
    load(exp_b);
    start();
    wait_we("t5_k2", 3);
    lb_wr(16'd6, 32'd1234);
    wait_we("t5_k5", 6);
    lb_wr(16'd1, 32'd999);
    wait_done("t5");
    check_burst("t5", exp_c);
    // full-scale values
    lb_wr(16'd0, 32'hFFFE0000);
    lb_wr(16'd1, 32'd131071);
    start();
    wait_done("t6");
    check_burst("t6", exp_d);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
